prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/instructions_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 57 +++++
 rtl/prefetch_unit.sv | 171 +++++++++++++++++
 tb/tb_prefetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instructions_pkg.sv
// Shared fetch-side definitions: address width and prefetch FSM states.
// FAULT exists only when PREFETCH_MISALIGN_TRAP_EN is defined.
package instructions_pkg;

    localparam int XLEN = 32;

`ifdef PREFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAULT = 2'd2
    } pf_state_e;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
    } pf_state_e;
`endif

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two instruction buffer with synchronous flush; the head entry is read combinationally.
// Flush overrides push and pop. Storage carries data only, so only pointers and count are reset.
module prefetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push && !flush;
    assign do_pop    = pop && !flush && (cnt != '0);
    assign head_data = mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign count     = cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: credit-limited in-order fetch into a small buffer, with redirect/drain handling.
// Optional PREFETCH_MISALIGN_TRAP_EN adds a FAULT state and the fetch_misaligned output.
module prefetch_unit
    import instructions_pkg::*;
#(
    parameter int               FIFO_DEPTH      = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
`ifdef PREFETCH_MISALIGN_TRAP_EN
    output logic [XLEN-1:0] inst_pc_pls4,
    output logic            fetch_misaligned
`else
    output logic [XLEN-1:0] inst_pc_pls4
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_OS  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [AQ_W-1:0]  AQ_LAST = AQ_W'(MAX_OUTSTANDING - 1);

    pf_state_e         state;
    pf_state_e         state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   redirect_tgt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  drop_cnt_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [XLEN-1:0]   aq_pc [MAX_OUTSTANDING];
    logic [AQ_W-1:0]   aq_wr;
    logic [AQ_W-1:0]   aq_rd;
    logic              can_issue;
    logic              grant;
    logic              push;
    logic              pop;
    logic [31:0]       head_inst;
    logic [XLEN-1:0]   head_pc;
`ifdef PREFETCH_MISALIGN_TRAP_EN
    logic              redirect_bad;

    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`endif

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // Credits: never more in flight than the buffer can still absorb.
    assign can_issue = (outstanding < MAX_OS) &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C);
    assign grant     = imem_req && imem_gnt;
    assign push      = imem_rvalid && (state == ST_RUN) && !redirect_valid;
    assign pop       = !fifo_empty && inst_ready;

    always_comb begin
        case ({grant, imem_rvalid})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    // Redirect counts this cycle's grant as stale and this cycle's response as already gone.
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt = outstanding_nxt;
        end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
`ifdef PREFETCH_MISALIGN_TRAP_EN
            if (redirect_bad) begin
                state_nxt = ST_FAULT;
            end else begin
                state_nxt = (drop_cnt_nxt != '0) ? ST_DRAIN : ST_RUN;
            end
`else
            state_nxt = (drop_cnt_nxt != '0) ? ST_DRAIN : ST_RUN;
`endif
        end else if (state == ST_DRAIN && drop_cnt_nxt == '0) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        case (state)
            ST_RUN, ST_DRAIN: imem_req = rstn && can_issue;
            default:          imem_req = 1'b0;
        endcase
`ifdef PREFETCH_MISALIGN_TRAP_EN
        fetch_misaligned = (state == ST_FAULT);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
            end else if (grant) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            // The address queue tracks every request, stale or not, so it stays aligned with responses.
            if (grant)       aq_wr <= (aq_wr == AQ_LAST) ? '0 : aq_wr + 1'b1;
            if (imem_rvalid) aq_rd <= (aq_rd == AQ_LAST) ? '0 : aq_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) aq_pc[aq_wr] <= fetch_pc;
    end

    prefetch_fifo #(
        .DATA_W (32 + XLEN),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({imem_rdata, aq_pc[aq_rd]}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data ({head_inst, head_pc}),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_addr    = fetch_pc;
    assign inst_valid   = !fifo_empty;
    assign inst         = fifo_empty ? '0 : head_inst;
    assign inst_pc      = fifo_empty ? '0 : head_pc;
    assign inst_pc_pls4 = inst_pc + XLEN'(4);

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a 1-cycle in-order memory model.
// Build with PREFETCH_MISALIGN_TRAP_EN to exercise the fault path.
module tb_prefetch_unit;
    import instructions_pkg::*;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_pls4;
`ifdef PREFETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned;
    logic            s_mis;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    logic            resp_en = 1'b0;
    logic            s_req;
    logic [31:0]     s_addr;
    logic [31:0]     pend[$];
    logic [31:0]     gnt_log[$];
    logic [31:0]     got_pc[$];
    logic [31:0]     got_inst[$];
    logic [31:0]     got_pls4[$];

    prefetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
`ifdef PREFETCH_MISALIGN_TRAP_EN
        .inst_pc_pls4   (inst_pc_pls4),
        .fetch_misaligned (fetch_misaligned)
`else
        .inst_pc_pls4   (inst_pc_pls4)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, respond one cycle after each grant.
    task automatic tick();
        @(negedge clk);
        s_req  = imem_req;
        s_addr = imem_addr;
`ifdef PREFETCH_MISALIGN_TRAP_EN
        s_mis  = fetch_misaligned;
`endif
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            gnt_log.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_inst.push_back(inst);
            got_pls4.push_back(inst_pc_pls4);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (resp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        got_pc.delete();
        got_inst.delete();
        got_pls4.delete();
    endtask

    task automatic reset_dut();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        resp_en        = 1'b0;
        pend.delete();
        clear_logs();
        #1;
        check("rst_req",   {31'd0, imem_req},   32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr",  imem_addr,    32'd0);
        check("rst_inst",  inst,         32'd0);
        check("rst_pc",    inst_pc,      32'd0);
        check("rst_pls4",  inst_pc_pls4, 32'd4);
`ifdef PREFETCH_MISALIGN_TRAP_EN
        check("rst_mis", {31'd0, fetch_misaligned}, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic redirect_tick(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        @(posedge clk);
        #1;

        // Streaming fetch: addresses and instruction order.
        reset_dut();
        #1;
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
        ticks(8);
        for (int i = 0; i < 3; i++) begin
            check("stream_gnt_addr", qat(gnt_log, i),  32'(4 * i));
            check("stream_pc",       qat(got_pc, i),   32'(4 * i));
            check("stream_pls4",     qat(got_pls4, i), 32'(4 * i + 4));
            check("stream_inst",     qat(got_inst, i), mem_word(32'(4 * i)));
        end

        // Consumer stalled: buffer depth caps grants.
        reset_dut();
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b0;
        ticks(12);
        check("stall_grants", 32'(gnt_log.size()), 32'd4);
        check("stall_req",    {31'd0, s_req}, 32'd0);
        check("stall_head",   inst_pc, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        check("stall_pop_pc",   qat(got_pc, 0), 32'd0);
        check("stall_req_back", {31'd0, s_req}, 32'd1);
        check("stall_addr",     s_addr, 32'h10);

        // Redirect with two requests in flight.
        reset_dut();
        redirect_tick(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1;
        ticks(2);
        check("os2_gnt0", qat(gnt_log, 0), 32'h10);
        check("os2_gnt1", qat(gnt_log, 1), 32'h14);
        redirect_tick(32'h100);
        check("os2_req_blocked", {31'd0, s_req}, 32'd0);
        resp_en = 1'b1;
        ticks(10);
        check("os2_pc0",   qat(got_pc, 0),   32'h100);
        check("os2_inst0", qat(got_inst, 0), mem_word(32'h100));
        check("os2_pc1",   qat(got_pc, 1),   32'h104);

        // Redirect coinciding with a grant and a response.
        reset_dut();
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
        ticks(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        check("coll_rvalid", {31'd0, imem_rvalid}, 32'd1);
        tick();
        check("coll_grant", {31'd0, s_req}, 32'd1);
        clear_logs();
        ticks(8);
        check("coll_pc0", qat(got_pc, 0), 32'h200);
        check("coll_pc1", qat(got_pc, 1), 32'h204);
        check("coll_pc2", qat(got_pc, 2), 32'h208);

        // Address wraps at the top of the space.
        reset_dut();
        redirect_tick(32'hFFFF_FFFC);
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
        tick();
        check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", s_addr, 32'h0);
        ticks(4);
        check("wrap_pc",   qat(got_pc, 0),   32'hFFFF_FFFC);
        check("wrap_pls4", qat(got_pls4, 0), 32'h0);

`ifdef PREFETCH_MISALIGN_TRAP_EN
        // Misaligned redirect faults until an aligned redirect.
        reset_dut();
        redirect_tick(32'h102);
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
        ticks(2);
        check("mis_flag", {31'd0, s_mis}, 32'd1);
        check("mis_req",  {31'd0, s_req}, 32'd0);
        redirect_tick(32'h200);
        tick();
        check("mis_clear", {31'd0, s_mis}, 32'd0);
        check("mis_req2",  {31'd0, s_req}, 32'd1);
        check("mis_addr",  s_addr, 32'h200);
        clear_logs();
        ticks(4);
        check("mis_pc", qat(got_pc, 0), 32'h200);
`else
        // Low target bits are ignored without the trap.
        reset_dut();
        redirect_tick(32'h102);
        imem_gnt = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
        tick();
        check("align_addr", s_addr, 32'h100);
        ticks(4);
        check("align_pc", qat(got_pc, 0), 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
